// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_pkg
// Brief    : Shared WS2812 receiver/transmitter state type and timing helpers.
// Revision : 1.0
// ============================================================================
package ws2812_pkg;

    localparam int DEF_CLK_FRE         = 50_000_000;
    localparam int DEF_T_BIT_THRESH_NS = 600;
    localparam int DEF_T_HIGH_MAX_NS   = 2000;
    localparam int DEF_T_RESET_NS      = 50000;

    typedef enum logic [1:0] {
        ST_WAIT_GAP = 2'd0,
        ST_IDLE     = 2'd1,
        ST_HIGH     = 2'd2,
        ST_LOW      = 2'd3
    } ws2812_state_t;

    // Whole-MHz clock scaling keeps the product inside 32 bits for realistic rates.
    function automatic int ns_to_cycles(input int clk_fre, input int t_ns);
        return (clk_fre / 1_000_000) * t_ns / 1000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_rx.sv
`default_nettype none
// ============================================================================
// Module   : ws2812_rx
// Brief    : WS2812 serial line decoder producing 24-bit words, frame and error pulses.
// Revision : 1.0
// ============================================================================
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int CLK_FRE         = DEF_CLK_FRE,
    parameter int T_BIT_THRESH_NS = DEF_T_BIT_THRESH_NS,
    parameter int T_HIGH_MAX_NS   = DEF_T_HIGH_MAX_NS,
    parameter int T_RESET_NS      = DEF_T_RESET_NS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] rgb,
    output logic        rgb_valid,
    output logic [7:0]  pixel_index,
    output logic        frame_done,
    output logic        err
);

    localparam int T_THRESH = ns_to_cycles(CLK_FRE, T_BIT_THRESH_NS);
    localparam int T_HMAX   = ns_to_cycles(CLK_FRE, T_HIGH_MAX_NS);
    localparam int T_RST    = ns_to_cycles(CLK_FRE, T_RESET_NS);
    localparam int TW       = $clog2(T_RST + 1);

    localparam logic [TW-1:0] THRESH_CNT = TW'(T_THRESH);
    localparam logic [TW-1:0] HMAX_CNT   = TW'(T_HMAX);
    localparam logic [TW-1:0] RST_CNT    = TW'(T_RST);

    logic          sync_q;
    logic          sdin;
    logic          sdin_d;
    logic          rise;
    logic          fall;
    logic [TW-1:0] timer;
    logic          bit_val;

    ws2812_state_t state;
    ws2812_state_t state_nxt;
    logic          take_bit;
    logic          hmax_err;
    logic          latch;
    logic          clear_frame;

    logic [22:0]   shreg;
    logic [4:0]    bit_cnt;
    logic [7:0]    word_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 1'b0;
            sdin   <= 1'b0;
            sdin_d <= 1'b0;
        end else begin
            sync_q <= din;
            sdin   <= sync_q;
            sdin_d <= sdin;
        end
    end

    assign rise = sdin & ~sdin_d;
    assign fall = ~sdin & sdin_d;

    // Timer reads 1 on the cycle after an edge, so at a falling edge it equals the high length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (rise || fall) begin
            timer <= TW'(1);
        end else if (timer != RST_CNT) begin
            timer <= timer + TW'(1);
        end
    end

    assign bit_val = (timer >= THRESH_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_WAIT_GAP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        take_bit    = 1'b0;
        hmax_err    = 1'b0;
        latch       = 1'b0;
        clear_frame = 1'b0;
        case (state)
            ST_WAIT_GAP: begin
                if (!sdin && timer == RST_CNT) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                clear_frame = 1'b1;
                if (rise) begin
                    state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    take_bit  = 1'b1;
                    state_nxt = ST_LOW;
                end else if (timer == HMAX_CNT) begin
                    hmax_err  = 1'b1;
                    state_nxt = ST_WAIT_GAP;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_nxt = ST_HIGH;
                end else if (timer == RST_CNT) begin
                    latch     = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_WAIT_GAP;
        endcase
    end

    // rgb is only written on a completed word; partial bits live in shreg/bit_cnt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            rgb         <= '0;
            rgb_valid   <= 1'b0;
            pixel_index <= '0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            rgb_valid  <= 1'b0;
            frame_done <= latch;
            err        <= hmax_err | (latch && bit_cnt != 5'd0);

            if (clear_frame || hmax_err || latch) begin
                bit_cnt <= '0;
            end
            if (clear_frame) begin
                word_cnt    <= '0;
                pixel_index <= '0;
            end

            if (take_bit) begin
                if (bit_cnt == 5'd23) begin
                    rgb         <= {shreg, bit_val};
                    rgb_valid   <= 1'b1;
                    pixel_index <= word_cnt;
                    bit_cnt     <= '0;
                    if (word_cnt != 8'hFF) begin
                        word_cnt <= word_cnt + 8'd1;
                    end
                end else begin
                    shreg   <= {shreg[21:0], bit_val};
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ws2812_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ws2812_rx
// Brief    : Directed waveform bench for ws2812_rx with a run-length reference model.
// Revision : 1.0
// ============================================================================
module tb_ws2812_rx;

    localparam int N_MAX    = 65536;
    localparam int T_THRESH = 30;
    localparam int T_HMAX   = 100;
    localparam int T_RST    = 2500;
    localparam int N_WORDS  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        din;
    logic [23:0] rgb;
    logic        rgb_valid;
    logic [7:0]  pixel_index;
    logic        frame_done;
    logic        err;

    ws2812_rx dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .rgb         (rgb),
        .rgb_valid   (rgb_valid),
        .pixel_index (pixel_index),
        .frame_done  (frame_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Stimulus waveform: one din/reset value per clock, applied just after each rising edge.
    bit          wave  [N_MAX];
    bit          rwave [N_MAX];
    int          n = 0;

    // Expected output events indexed by sample (a line decision at index k shows at k+3).
    bit          ev_valid [N_MAX];
    bit          ev_done  [N_MAX];
    bit          ev_err   [N_MAX];
    bit          ev_clr   [N_MAX];
    logic [23:0] ev_rgb   [N_MAX];
    logic [7:0]  ev_idx   [N_MAX];

    int          total = 0;
    int          bad   = 0;
    int          cur   = -1;
    bit          running = 1'b0;
    bit          drive_done = 1'b0;

    logic [23:0] h_rgb = '0;
    logic [7:0]  h_idx = '0;
    bit          e_v, e_d, e_e;
    logic [31:0] vlog[$];
    int          n_done = 0, n_err = 0, n_both = 0;
    int          m_valid, m_done, m_err;
    logic [31:0] exp_log [N_WORDS];

    task automatic seg(input bit lvl, input int len, input bit r);
        for (int i = 0; i < len; i++) begin
            wave[n]  = lvl;
            rwave[n] = r;
            n++;
        end
    endtask

    task automatic send_bit_h(input int high);
        seg(1'b1, high, 1'b0);
        seg(1'b0, 62 - high, 1'b0);
    endtask

    task automatic send_bits(input logic [23:0] v, input int cnt);
        for (int i = 23; i > 23 - cnt; i--) begin
            send_bit_h(v[i] ? 40 : 20);
        end
    endtask

    // Walks the waveform as runs of constant level and applies the protocol rules to run lengths.
    task automatic build_model();
        bit          armed   = 1'b0;
        bit          in_word = 1'b0;
        bit          lvl     = 1'b0;
        int          last    = 0;
        int          nbits   = 0;
        int          widx    = 0;
        logic [23:0] acc     = '0;
        for (int k = 0; k < n; k++) begin
            if (rwave[k]) begin
                armed = 1'b0; in_word = 1'b0; lvl = 1'b0; last = k; nbits = 0; widx = 0;
                for (int j = k; j <= k + 2; j++) begin
                    ev_valid[j] = 1'b0; ev_done[j] = 1'b0; ev_err[j] = 1'b0; ev_clr[j] = 1'b0;
                end
            end else if (wave[k] != lvl) begin
                if (lvl && in_word) begin
                    acc = {acc[22:0], ((k - last) >= T_THRESH)};
                    nbits++;
                    if (nbits == 24) begin
                        ev_valid[k+3] = 1'b1;
                        ev_rgb[k+3]   = acc;
                        ev_idx[k+3]   = 8'(widx);
                        if (widx < 255) widx++;
                        nbits = 0;
                    end
                end else if (!lvl && armed) begin
                    in_word = 1'b1;
                end
                lvl  = wave[k];
                last = k;
            end else if (lvl && in_word && (k - last) == T_HMAX) begin
                ev_err[k+3] = 1'b1;
                armed = 1'b0; in_word = 1'b0; nbits = 0;
            end else if (!lvl && (k - last) == T_RST) begin
                if (in_word) begin
                    ev_done[k+3] = 1'b1;
                    if (nbits != 0) ev_err[k+3] = 1'b1;
                end
                if (!armed || in_word) ev_clr[k+4] = 1'b1;
                armed = 1'b1; in_word = 1'b0; nbits = 0; widx = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (running && cur >= 0 && !drive_done) begin
            if (rwave[cur]) begin
                h_rgb = '0; h_idx = '0; e_v = 1'b0; e_d = 1'b0; e_e = 1'b0;
            end else begin
                if (ev_clr[cur]) h_idx = '0;
                if (ev_valid[cur]) begin
                    h_rgb = ev_rgb[cur];
                    h_idx = ev_idx[cur];
                end
                e_v = ev_valid[cur]; e_d = ev_done[cur]; e_e = ev_err[cur];
            end
            total++;
            if ({rgb, rgb_valid, pixel_index, frame_done, err} !== {h_rgb, e_v, h_idx, e_d, e_e}) begin
                bad++;
                $display("FAIL cycle %0d outputs: rgb=%h valid=%b idx=%0d done=%b err=%b; required rgb=%h valid=%b idx=%0d done=%b err=%b",
                         cur, rgb, rgb_valid, pixel_index, frame_done, err, h_rgb, e_v, h_idx, e_d, e_e);
            end
            if (rgb_valid === 1'b1) vlog.push_back({pixel_index, rgb});
            if (frame_done === 1'b1) n_done++;
            if (err === 1'b1) n_err++;
            if (frame_done === 1'b1 && err === 1'b1) n_both++;
        end else if (drive_done) begin
            m_valid = 0; m_done = 0; m_err = 0;
            for (int k = 0; k < N_MAX; k++) begin
                m_valid += int'(ev_valid[k]);
                m_done  += int'(ev_done[k]);
                m_err   += int'(ev_err[k]);
            end
            total++;
            if (m_valid != N_WORDS || m_done != 6 || m_err != 2) begin
                bad++;
                $display("FAIL model_counts: valid=%0d done=%0d err=%0d; required 10 6 2", m_valid, m_done, m_err);
            end
            total++;
            if (vlog.size() != N_WORDS) begin
                bad++;
                $display("FAIL word_count: got %0d required %0d", vlog.size(), N_WORDS);
            end
            for (int i = 0; i < N_WORDS; i++) begin
                total++;
                if (i >= vlog.size() || vlog[i] !== exp_log[i]) begin
                    bad++;
                    $display("FAIL word_%0d: got %h required %h", i, (i < vlog.size()) ? vlog[i] : 32'hxxxxxxxx, exp_log[i]);
                end
            end
            total++;
            if (n_done != 6) begin
                bad++;
                $display("FAIL frame_done_count: got %0d required 6", n_done);
            end
            total++;
            if (n_err != 2) begin
                bad++;
                $display("FAIL err_count: got %0d required 2", n_err);
            end
            total++;
            if (n_both != 1) begin
                bad++;
                $display("FAIL partial_latch_coincide: got %0d required 1", n_both);
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        reset = 1'b1;
        din   = 1'b0;

        exp_log[0] = {8'd0, 24'hA5C33C};
        exp_log[1] = {8'd0, 24'h000001};
        exp_log[2] = {8'd1, 24'hFFFFFF};
        exp_log[3] = {8'd2, 24'h800000};
        exp_log[4] = {8'd0, 24'h123456};
        exp_log[5] = {8'd0, 24'h0F0F0F};
        exp_log[6] = {8'd0, 24'h111111};
        exp_log[7] = {8'd0, 24'h333333};
        exp_log[8] = {8'd1, 24'h444444};
        exp_log[9] = {8'd0, 24'h555555};

        seg(1'b0, 5, 1'b1);
        seg(1'b0, 2600, 1'b0);
        // single word frame
        send_bits(24'hA5C33C, 24);
        seg(1'b0, 2600, 1'b0);
        // three back-to-back words
        send_bits(24'h000001, 24);
        send_bits(24'hFFFFFF, 24);
        send_bits(24'h800000, 24);
        seg(1'b0, 2600, 1'b0);
        // over-long high pulse mid-word, then ignored bits
        send_bits(24'h123456, 24);
        send_bits(24'hF00000, 5);
        seg(1'b1, 120, 1'b0);
        seg(1'b0, 22, 1'b0);
        send_bits(24'hABCDEF, 24);
        seg(1'b0, 2600, 1'b0);
        // partial word before latch
        send_bits(24'hFFC000, 10);
        seg(1'b0, 2600, 1'b0);
        send_bits(24'h0F0F0F, 24);
        seg(1'b0, 2600, 1'b0);
        // reset, bits without gap, then reset during word 2
        seg(1'b0, 5, 1'b1);
        seg(1'b0, 50, 1'b0);
        send_bits(24'hABCDEF, 24);
        seg(1'b0, 2600, 1'b0);
        send_bits(24'h111111, 24);
        send_bits(24'h222222, 12);
        seg(1'b0, 5, 1'b1);
        seg(1'b0, 2600, 1'b0);
        send_bits(24'h333333, 24);
        send_bits(24'h444444, 24);
        seg(1'b0, 2600, 1'b0);
        // threshold boundary: 29 high -> 0, 30 high -> 1
        for (int i = 0; i < 24; i++) begin
            send_bit_h((i % 2 == 1) ? T_THRESH : T_THRESH - 1);
        end
        seg(1'b0, 2600, 1'b0);
        seg(1'b0, 10, 1'b0);

        build_model();
        running = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            din   = wave[k];
            reset = rwave[k];
            cur   = k;
        end
        @(posedge clk);
        #1;
        drive_done = 1'b1;
        #200;
        $display("FAIL timeout: summary not reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
